// File: rtl/cpu_bus_master_if.sv
// Request/response and cartridge CPU bus signals of cpu_bus_master.
// Request handshake: a request transfers on a rising clk edge where req_valid && req_ready;
// req_addr/req_rw/req_wdata must be stable while req_valid is high. rsp_valid is a
// one-clk pulse with no back-pressure.
interface cpu_bus_master_if;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_addr;
  logic        req_rw;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        m2;
  logic        romsel;
  logic        cpu_rw;
  logic [14:0] cpu_addr_out;
  logic [7:0]  cpu_data_out;
  logic        cpu_data_oe;
  logic [7:0]  cpu_data_in;
  logic        irq_n;
  logic        irq_active;
  logic [1:0]  dbg_cycle;

  modport master (
    input  req_valid, req_addr, req_rw, req_wdata, cpu_data_in, irq_n,
    output req_ready, rsp_valid, rsp_rdata, m2, romsel, cpu_rw,
    output cpu_addr_out, cpu_data_out, cpu_data_oe, irq_active, dbg_cycle
  );

  modport slave (
    output req_valid, req_addr, req_rw, req_wdata, cpu_data_in, irq_n,
    input  req_ready, rsp_valid, rsp_rdata, m2, romsel, cpu_rw,
    input  cpu_addr_out, cpu_data_out, cpu_data_oe, irq_active, dbg_cycle
  );
endinterface

// File: rtl/cpu_bus_master.sv
// Console-side NES/Famicom CPU bus initiator with a free-running M2 and a one-entry request buffer.
// Optional macro CPU_BUS_MASTER_IRQ_SYNC_EN enables the 2-flop /IRQ synchronizer.
module cpu_bus_master #(
  parameter int PHI_LOW_CYCLES  = 6,
  parameter int PHI_HIGH_CYCLES = 6
) (
  input  logic clk,
  input  logic rst_n,
  cpu_bus_master_if.master bus
);
  localparam int PERIOD = PHI_LOW_CYCLES + PHI_HIGH_CYCLES;
  localparam int PH_W   = $clog2(PERIOD);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(PERIOD - 1);
  localparam logic [PH_W-1:0] PH_HIGH = PH_W'(PHI_LOW_CYCLES);

  typedef enum logic [1:0] {
    CYC_IDLE  = 2'd0,
    CYC_READ  = 2'd1,
    CYC_WRITE = 2'd2
  } cyc_e;

  cyc_e            state, state_nx;
  logic [PH_W-1:0] ph, ph_nx;
  logic            full, full_nx;
  logic [15:0]     buf_addr;
  logic            buf_rw;
  logic [7:0]      buf_wdata;
  logic            a15, a15_nx;
  logic [14:0]     addr_q, addr_nx;
  logic [7:0]      wdata_q, wdata_nx;
  logic            m2_q, m2_nx;
  logic            romsel_q, romsel_nx;
  logic            oe_q, oe_nx;
  logic            rsp_q, rsp_nx;
  logic [7:0]      rdata_q, rdata_nx;
  logic            boundary;
  logic            accept;

  always_comb begin
    boundary  = (ph == PH_LAST);
    accept    = bus.req_valid && !full;
    ph_nx     = boundary ? '0 : ph + 1'b1;
    state_nx  = state;
    full_nx   = full;
    a15_nx    = a15;
    addr_nx   = addr_q;
    wdata_nx  = wdata_q;
    rsp_nx    = 1'b0;
    rdata_nx  = rdata_q;
    if (boundary) begin
      // The last m2-high clk of a read is where the cartridge data is taken.
      if (state == CYC_READ) begin
        rsp_nx   = 1'b1;
        rdata_nx = bus.cpu_data_in;
      end
      if (full) begin
        state_nx = buf_rw ? CYC_READ : CYC_WRITE;
        addr_nx  = buf_addr[14:0];
        a15_nx   = buf_addr[15];
        full_nx  = 1'b0;
        if (!buf_rw) wdata_nx = buf_wdata;
      end else begin
        // Dummy read keeps M2 running; A15 cleared so /ROMSEL never asserts.
        state_nx = CYC_IDLE;
        a15_nx   = 1'b0;
      end
    end
    if (accept) full_nx = 1'b1;
    m2_nx     = (ph_nx >= PH_HIGH);
    romsel_nx = ~(m2_nx & a15_nx);
    oe_nx     = m2_nx & (state_nx == CYC_WRITE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph        <= '0;
      state     <= CYC_IDLE;
      full      <= 1'b0;
      buf_addr  <= '0;
      buf_rw    <= 1'b1;
      buf_wdata <= '0;
      a15       <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      m2_q      <= 1'b0;
      romsel_q  <= 1'b1;
      oe_q      <= 1'b0;
      rsp_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      ph       <= ph_nx;
      state    <= state_nx;
      full     <= full_nx;
      a15      <= a15_nx;
      addr_q   <= addr_nx;
      wdata_q  <= wdata_nx;
      m2_q     <= m2_nx;
      romsel_q <= romsel_nx;
      oe_q     <= oe_nx;
      rsp_q    <= rsp_nx;
      rdata_q  <= rdata_nx;
      if (accept) begin
        buf_addr  <= bus.req_addr;
        buf_rw    <= bus.req_rw;
        buf_wdata <= bus.req_wdata;
      end
    end
  end

  assign bus.req_ready    = ~full;
  assign bus.rsp_valid    = rsp_q;
  assign bus.rsp_rdata    = rdata_q;
  assign bus.m2           = m2_q;
  assign bus.romsel       = romsel_q;
  assign bus.cpu_rw       = (state != CYC_WRITE);
  assign bus.cpu_addr_out = addr_q;
  assign bus.cpu_data_out = wdata_q;
  assign bus.cpu_data_oe  = oe_q;
  assign bus.dbg_cycle    = state;

`ifdef CPU_BUS_MASTER_IRQ_SYNC_EN
  logic [1:0] irq_sync;

  // Anything other than a solid 0 reads as the pulled-up idle level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_sync <= 2'b11;
    else        irq_sync <= {irq_sync[0], (bus.irq_n !== 1'b0)};
  end

  assign bus.irq_active = ~irq_sync[1];
`else
  logic unused_irq;
  assign unused_irq     = bus.irq_n;
  assign bus.irq_active = 1'b0;
`endif
endmodule

// File: tb/tb_cpu_bus_master.sv
// Self-checking bench for cpu_bus_master: cartridge memory model, request scoreboard,
// table-driven single-cycle vectors and hand-written multi-cycle sequences.
module tb_cpu_bus_master;
  localparam int PHI_LOW = 6;
  localparam int PHI_HIGH = 6;
  localparam int PERIOD = PHI_LOW + PHI_HIGH;

  logic clk;
  logic rst_n;
  cpu_bus_master_if bus ();

  cpu_bus_master #(.PHI_LOW_CYCLES(PHI_LOW), .PHI_HIGH_CYCLES(PHI_HIGH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tb_t;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_t <= 0;
    else        tb_t <= tb_t + 1;
  end

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0d)", name, act, exp, tb_t);
    end
  endfunction

  function automatic void flag(input string name, input string what);
    n_tests++;
    n_fail++;
    $display("FAIL %s: %s (t=%0d)", name, what, tb_t);
  endfunction

  function automatic logic [7:0] pat(input logic [14:0] a);
    return 8'hA5 ^ a[7:0] ^ {1'b0, a[14:8]};
  endfunction

  // ---------------- cartridge model and scoreboard ----------------
  logic [7:0]  cart_mem [0:32767];
  logic [7:0]  shadow   [0:32767];
  logic        cart_init = 1'b0;
  logic [7:0]  exp_q[$];
  logic [23:0] exp_wr_q[$];

  assign bus.cpu_data_in = cart_mem[bus.cpu_addr_out];

  always @(negedge clk) begin
    int ph;
    logic [7:0]  e;
    logic [23:0] w;
    if (!cart_init) begin
      for (int i = 0; i < 32768; i++) cart_mem[i] = pat(15'(i));
      cart_init = 1'b1;
    end
    if (rst_n) begin
      ph = tb_t % PERIOD;
      chk("m2_phase", bus.m2, (ph >= PHI_LOW));
      if (!bus.m2) chk("romsel_while_m2_low", bus.romsel, 1'b1);
      if (bus.rsp_valid) begin
        chk("rsp_phase", ph, 0);
        if (exp_q.size() == 0) flag("rsp_unexpected", "rsp_valid with no read outstanding");
        else begin
          e = exp_q.pop_front();
          chk("rsp_rdata", bus.rsp_rdata, e);
        end
      end
      if (ph == PERIOD - 1 && !bus.cpu_rw) begin
        chk("write_oe_high", bus.cpu_data_oe, 1'b1);
        if (exp_wr_q.size() == 0) flag("write_unexpected", "write cycle with no write outstanding");
        else begin
          w = exp_wr_q.pop_front();
          chk("write_cycle", {~bus.romsel, bus.cpu_addr_out, bus.cpu_data_out}, w);
        end
        cart_mem[bus.cpu_addr_out] = bus.cpu_data_out;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a negedge; returns on the negedge following acceptance.
  task automatic send(input logic rw, input logic [15:0] a, input logic [7:0] d);
    int n = 0;
    while (!bus.req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      flag("send_timeout", "req_ready never rose within 40 clks");
      return;
    end
    bus.req_valid = 1'b1;
    bus.req_rw    = rw;
    bus.req_addr  = a;
    bus.req_wdata = d;
    @(negedge clk);
    bus.req_valid = 1'b0;
    if (rw) exp_q.push_back(shadow[a[14:0]]);
    else begin
      exp_wr_q.push_back({a, d});
      shadow[a[14:0]] = d;
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_req_ready"}, bus.req_ready, 1'b1);
    chk({tag, "_rsp_valid"}, bus.rsp_valid, 1'b0);
    chk({tag, "_rsp_rdata"}, bus.rsp_rdata, 8'h00);
    chk({tag, "_m2"}, bus.m2, 1'b0);
    chk({tag, "_romsel"}, bus.romsel, 1'b1);
    chk({tag, "_cpu_rw"}, bus.cpu_rw, 1'b1);
    chk({tag, "_addr"}, bus.cpu_addr_out, 15'h0000);
    chk({tag, "_data_out"}, bus.cpu_data_out, 8'h00);
    chk({tag, "_data_oe"}, bus.cpu_data_oe, 1'b0);
    chk({tag, "_irq_active"}, bus.irq_active, 1'b0);
  endtask

  typedef struct {
    logic        rw;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [14:0] exp_addr;
    int          exp_romsel_low;
    int          exp_oe;
    int          exp_rw_low;
    int          exp_rsp;
    logic [7:0]  exp_rdata;
  } vec_t;

  vec_t vecs [6];

  task automatic run_vec(input vec_t v, input int idx);
    int n_addr_bad = 0, n_data_bad = 0, n_rs = 0, n_oe = 0, n_rwl = 0, n_rsp = 0, guard = 0;
    logic [7:0] got_rd = 8'h00;
    send(v.rw, v.addr, v.wdata);
    do begin
      @(negedge clk);
      guard++;
    end while ((tb_t % PERIOD) != 0 && guard < 40);
    if (guard >= 40) flag($sformatf("vec%0d_launch", idx), "no cycle boundary within 40 clks");
    for (int i = 0; i <= PERIOD; i++) begin
      if (i < PERIOD) begin
        if (bus.cpu_addr_out !== v.exp_addr) n_addr_bad++;
        if (!v.rw && bus.cpu_data_out !== v.wdata) n_data_bad++;
        if (!bus.romsel) n_rs++;
        if (bus.cpu_data_oe) n_oe++;
        if (!bus.cpu_rw) n_rwl++;
      end
      if (bus.rsp_valid) begin
        n_rsp++;
        got_rd = bus.rsp_rdata;
      end
      if (i < PERIOD) @(negedge clk);
    end
    chk($sformatf("vec%0d_addr_bad_clks", idx), n_addr_bad, 0);
    chk($sformatf("vec%0d_romsel_low_clks", idx), n_rs, v.exp_romsel_low);
    chk($sformatf("vec%0d_oe_clks", idx), n_oe, v.exp_oe);
    chk($sformatf("vec%0d_rw_low_clks", idx), n_rwl, v.exp_rw_low);
    chk($sformatf("vec%0d_rsp_count", idx), n_rsp, v.exp_rsp);
    if (v.rw) chk($sformatf("vec%0d_rdata", idx), got_rd, v.exp_rdata);
    else      chk($sformatf("vec%0d_wdata_bad_clks", idx), n_data_bad, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int t_rise, t_fall, t_rd, t_wr, t_rsp, n_rsp, n_rwl, n_rs, guard;
    logic [7:0] rd, exp_rd;
    logic exp_irq;

    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_rw    = 1'b1;
    bus.req_wdata = '0;
    bus.irq_n     = 1'b1;
    for (int i = 0; i < 32768; i++) shadow[i] = pat(15'(i));

    vecs[0] = '{1'b1, 16'h8000, 8'h00, 15'h0000, 6, 0, 0,  1, 8'hA5};
    vecs[1] = '{1'b0, 16'h6000, 8'h3C, 15'h6000, 0, 6, 12, 0, 8'h00};
    vecs[2] = '{1'b1, 16'h0123, 8'h00, 15'h0123, 0, 0, 0,  1, 8'h87};
    vecs[3] = '{1'b0, 16'hFFFF, 8'hC3, 15'h7FFF, 6, 6, 12, 0, 8'h00};
    vecs[4] = '{1'b1, 16'hFFFC, 8'h00, 15'h7FFC, 6, 0, 0,  1, 8'h26};
    vecs[5] = '{1'b0, 16'h0000, 8'h00, 15'h0000, 0, 6, 12, 0, 8'h00};

    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;

    // Idle bus after release: M2 edges at 6 and 12, no /ROMSEL, no writes.
    t_rise = -1; t_fall = -1; n_rs = 0; n_rwl = 0;
    for (int i = 0; i < 2 * PERIOD; i++) begin
      if (bus.m2 && t_rise < 0) t_rise = tb_t;
      if (!bus.m2 && t_rise >= 0 && t_fall < 0) t_fall = tb_t;
      if (!bus.romsel) n_rs++;
      if (!bus.cpu_rw) n_rwl++;
      @(negedge clk);
    end
    chk("idle_m2_rise", t_rise, PHI_LOW);
    chk("idle_m2_fall", t_fall, PERIOD);
    chk("idle_romsel_low_clks", n_rs, 0);
    chk("idle_rw_low_clks", n_rwl, 0);

    for (int k = 0; k < 6; k++) run_vec(vecs[k], k);

    // Back-to-back read then write: contiguous cycles, one response.
    exp_rd = shadow[15'h4123];
    send(1'b1, 16'hC123, 8'h00);
    send(1'b0, 16'h8001, 8'h80);
    chk("b2b_ready_after_2nd", bus.req_ready, 1'b0);
    t_rd = -1; t_wr = -1; t_rsp = -1; n_rsp = 0; rd = 8'h00;
    for (int i = 0; i < 40; i++) begin
      if (!bus.romsel && bus.cpu_rw && t_rd < 0) t_rd = tb_t;
      if (!bus.cpu_rw && t_wr < 0) t_wr = tb_t;
      if (bus.rsp_valid) begin
        n_rsp++;
        t_rsp = tb_t;
        rd = bus.rsp_rdata;
      end
      @(negedge clk);
    end
    chk("b2b_write_start", t_wr, t_rd + PHI_HIGH);
    chk("b2b_rsp_time", t_rsp, t_wr);
    chk("b2b_rsp_count", n_rsp, 1);
    chk("b2b_rdata", rd, exp_rd);

    // Reset on the 3rd m2-high clk of a write with another request buffered.
    send(1'b0, 16'h6010, 8'h11);
    send(1'b0, 16'h8002, 8'h22);
    guard = 0;
    while (!(!bus.cpu_rw && (tb_t % PERIOD) == PHI_LOW + 2) && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 40) flag("midrst_wait", "write never reached 3rd m2-high clk");
    rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    exp_q.delete();
    exp_wr_q.delete();
    shadow = cart_mem;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n_rsp = 0; n_rwl = 0;
    for (int i = 0; i < 3 * PERIOD; i++) begin
      if (!bus.cpu_rw) n_rwl++;
      if (bus.rsp_valid) n_rsp++;
      @(negedge clk);
    end
    chk("midrst_no_write_after", n_rwl, 0);
    chk("midrst_no_rsp_after", n_rsp, 0);

    // Random traffic against the memory model.
    for (int i = 0; i < 60; i++) begin
      send(1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom));
      repeat ($urandom_range(0, 14)) @(negedge clk);
    end
    guard = 0;
    while ((exp_q.size() != 0 || exp_wr_q.size() != 0) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_reads", exp_q.size(), 0);
    chk("drain_writes", exp_wr_q.size(), 0);

    // /IRQ pulse of 5 clks.
    bus.irq_n = 1'b0;
    for (int o = 1; o <= 8; o++) begin
      @(negedge clk);
`ifdef CPU_BUS_MASTER_IRQ_SYNC_EN
      exp_irq = (o >= 2 && o <= 6);
`else
      exp_irq = 1'b0;
`endif
      chk($sformatf("irq_active_o%0d", o), bus.irq_active, exp_irq);
      if (o == 5) bus.irq_n = 1'b1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
